// File: rtl/tomasulo_pkg.sv
// Shared types and constants for the Tomasulo reservation station.
//   INVALID_TAG : producer-tag value meaning "operand value is present"
//   TAG_W/DATA_W/OP_W : tag, data and operator-class widths
//   rs_entry_t  : one reservation-station slot
//   cdb_hit()   : true when a CDB broadcast resolves a given operand tag
package tomasulo_pkg;
  localparam int TAG_W  = 5;
  localparam int DATA_W = 32;
  localparam int OP_W   = 5;

  localparam logic [TAG_W-1:0] INVALID_TAG = 5'b11111;

  typedef struct packed {
    logic              busy;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] val_1;
    logic [DATA_W-1:0] val_2;
    logic [TAG_W-1:0]  tag_1;
    logic [TAG_W-1:0]  tag_2;
  } rs_entry_t;

  localparam rs_entry_t RS_ENTRY_RST = '{
    busy:  1'b0,
    op:    '0,
    val_1: '0,
    val_2: '0,
    tag_1: INVALID_TAG,
    tag_2: INVALID_TAG
  };

  // A broadcast of INVALID_TAG must never wake an operand that is already
  // resolved, so it is excluded explicitly.
  function automatic logic cdb_hit(input logic             bcast,
                                   input logic [TAG_W-1:0] cdb_tag,
                                   input logic [TAG_W-1:0] op_tag);
    return bcast && (cdb_tag != INVALID_TAG) && (op_tag == cdb_tag);
  endfunction
endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-set-bit priority encoder.
//   W       : request vector width (>= 2)
//   req_i   : request bits
//   idx_o   : index of the lowest set bit (0 when none set)
//   found_o : at least one request bit set
module rs_prio_enc #(
  parameter int W = 4
) (
  input  logic [W-1:0]         req_i,
  output logic [$clog2(W)-1:0] idx_o,
  output logic                 found_o
);
  localparam int IDX_W = $clog2(W);

  // Scan high to low so the last hit written is the lowest index.
  always_comb begin
    idx_o   = '0;
    found_o = |req_i;
    for (int i = W - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end
endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station.
// Accepts one decoded instruction per cycle into the lowest free entry and
// reports the allocated tag one cycle later, captures pending operands from
// the CDB, and offers the lowest-index fully ready entry to the functional
// unit over a valid/ready handshake.
//
// Parameters: DEPTH (2..8 entries), TAG_BASE (tag of entry 0).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_dispatch_valid / out_dispatch_ready, in_operator_type,
//   in_val_1/2, in_tag_1/2     dispatch side
//   out_alloc_valid/out_alloc_tag  one-cycle allocation report for renaming
//   in_CDB_broadcast/tag/val   common data bus snoop
//   out_issue_valid / in_issue_ready, out_issue_operator_type,
//   out_issue_val_1/2, out_issue_tag  functional-unit issue side
//
// Build option RS_DISPATCH_BYPASS_EN: when defined, a dispatching operand
// whose tag is being broadcast this cycle is captured directly from the CDB;
// when undefined, dispatch stalls for any cycle carrying a CDB broadcast.
module reservation_station
  import tomasulo_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int TAG_BASE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_dispatch_valid,
  output logic              out_dispatch_ready,
  input  logic [OP_W-1:0]   in_operator_type,
  input  logic [DATA_W-1:0] in_val_1,
  input  logic [DATA_W-1:0] in_val_2,
  input  logic [TAG_W-1:0]  in_tag_1,
  input  logic [TAG_W-1:0]  in_tag_2,
  output logic              out_alloc_valid,
  output logic [TAG_W-1:0]  out_alloc_tag,
  input  logic              in_CDB_broadcast,
  input  logic [TAG_W-1:0]  in_CDB_tag,
  input  logic [DATA_W-1:0] in_CDB_val,
  output logic              out_issue_valid,
  input  logic              in_issue_ready,
  output logic [OP_W-1:0]   out_issue_operator_type,
  output logic [DATA_W-1:0] out_issue_val_1,
  output logic [DATA_W-1:0] out_issue_val_2,
  output logic [TAG_W-1:0]  out_issue_tag
);
  localparam int IDX_W = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > 8) begin : g_bad_depth
    $error("reservation_station: DEPTH must be 2..8");
  end
  if (TAG_BASE < 0 || TAG_BASE + DEPTH - 1 >= 31) begin : g_bad_tag_base
    $error("reservation_station: tag range collides with INVALID_TAG");
  end

  rs_entry_t ent_q [DEPTH];
  rs_entry_t ent_d [DEPTH];

  logic             alloc_valid_q, alloc_valid_d;
  logic [TAG_W-1:0] alloc_tag_q, alloc_tag_d;

  logic [DEPTH-1:0] free_vec, rdy_vec;
  logic [IDX_W-1:0] free_idx, rdy_idx;
  logic             free_found, rdy_found;
  logic             disp_fire, iss_fire;

  // Both select vectors come from registered state only: a slot freed by
  // issue this cycle is not reusable until next cycle, and a CDB wakeup
  // this cycle does not issue until next cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      free_vec[i] = !ent_q[i].busy;
      rdy_vec[i]  = ent_q[i].busy && (ent_q[i].tag_1 == INVALID_TAG)
                                  && (ent_q[i].tag_2 == INVALID_TAG);
    end
  end

  rs_prio_enc #(.W(DEPTH)) u_free_sel (
    .req_i   (free_vec),
    .idx_o   (free_idx),
    .found_o (free_found)
  );

  rs_prio_enc #(.W(DEPTH)) u_rdy_sel (
    .req_i   (rdy_vec),
    .idx_o   (rdy_idx),
    .found_o (rdy_found)
  );

  // Incoming operand fields as they will be stored.
  logic [DATA_W-1:0] d_val_1, d_val_2;
  logic [TAG_W-1:0]  d_tag_1, d_tag_2;

`ifdef RS_DISPATCH_BYPASS_EN
  assign out_dispatch_ready = free_found;

  always_comb begin
    d_val_1 = in_val_1;
    d_tag_1 = in_tag_1;
    d_val_2 = in_val_2;
    d_tag_2 = in_tag_2;
    if (cdb_hit(in_CDB_broadcast, in_CDB_tag, in_tag_1)) begin
      d_val_1 = in_CDB_val;
      d_tag_1 = INVALID_TAG;
    end
    if (cdb_hit(in_CDB_broadcast, in_CDB_tag, in_tag_2)) begin
      d_val_2 = in_CDB_val;
      d_tag_2 = INVALID_TAG;
    end
  end
`else
  // Without a forwarding path a producer broadcasting this cycle would be
  // missed by the new entry, so dispatch simply waits out the broadcast.
  assign out_dispatch_ready = free_found && !in_CDB_broadcast;

  assign d_val_1 = in_val_1;
  assign d_tag_1 = in_tag_1;
  assign d_val_2 = in_val_2;
  assign d_tag_2 = in_tag_2;
`endif

  assign disp_fire = in_dispatch_valid && out_dispatch_ready;
  assign iss_fire  = rdy_found && in_issue_ready;

  // Issue offer is purely combinational from the lowest ready entry; it only
  // moves when that entry leaves or a lower-index entry becomes ready.
  always_comb begin
    out_issue_valid         = rdy_found;
    out_issue_operator_type = '0;
    out_issue_val_1         = '0;
    out_issue_val_2         = '0;
    out_issue_tag           = INVALID_TAG;
    if (rdy_found) begin
      out_issue_operator_type = ent_q[rdy_idx].op;
      out_issue_val_1         = ent_q[rdy_idx].val_1;
      out_issue_val_2         = ent_q[rdy_idx].val_2;
      out_issue_tag           = TAG_W'(TAG_BASE) + TAG_W'(rdy_idx);
    end
  end

  // The issuing entry has no pending tags and the dispatch target is not
  // busy, so CDB capture, issue clear and dispatch write never collide.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].busy && cdb_hit(in_CDB_broadcast, in_CDB_tag, ent_q[i].tag_1)) begin
        ent_d[i].val_1 = in_CDB_val;
        ent_d[i].tag_1 = INVALID_TAG;
      end
      if (ent_q[i].busy && cdb_hit(in_CDB_broadcast, in_CDB_tag, ent_q[i].tag_2)) begin
        ent_d[i].val_2 = in_CDB_val;
        ent_d[i].tag_2 = INVALID_TAG;
      end
    end
    if (iss_fire) ent_d[rdy_idx].busy = 1'b0;
    if (disp_fire) begin
      ent_d[free_idx] = '{
        busy:  1'b1,
        op:    in_operator_type,
        val_1: d_val_1,
        val_2: d_val_2,
        tag_1: d_tag_1,
        tag_2: d_tag_2
      };
    end
  end

  // Alloc tag holds its last value between pulses; only the valid pulses.
  always_comb begin
    alloc_valid_d = disp_fire;
    alloc_tag_d   = alloc_tag_q;
    if (disp_fire) alloc_tag_d = TAG_W'(TAG_BASE) + TAG_W'(free_idx);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= RS_ENTRY_RST;
      alloc_valid_q <= 1'b0;
      alloc_tag_q   <= INVALID_TAG;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      alloc_valid_q <= alloc_valid_d;
      alloc_tag_q   <= alloc_tag_d;
    end
  end

  assign out_alloc_valid = alloc_valid_q;
  assign out_alloc_tag   = alloc_tag_q;
endmodule

// File: doc/reservation_station.md
# reservation_station

Clocked Tomasulo reservation station directly downstream of the current-instruction dispatch stage. It accepts one decoded instruction per cycle (operator type, two operands as value or producer tag) and returns the allocated RS tag for register-bank renaming. It snoops the CDB to capture pending operands and issues the lowest-index fully ready entry to its functional unit over a valid/ready handshake.

## Interface
- DEPTH, 4, number of entries (2..8)
- TAG_BASE, 0, tag of entry 0; entry i owns tag TAG_BASE+i; elaboration error if TAG_BASE+DEPTH-1 >= 31
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- in_dispatch_valid  in  1  dispatch request
- out_dispatch_ready  out  1  entry free and dispatch accepted this cycle if valid
- in_operator_type  in  5  opcode class
- in_val_1 / in_val_2  in  32  operand values (meaningful when matching tag == INVALID_TAG)
- in_tag_1 / in_tag_2  in  5  producer tags; INVALID_TAG (5'b11111) = value present
- out_alloc_valid  out  1  one-cycle pulse: tag allocated
- out_alloc_tag  out  5  allocated tag, for the bank rename write
- in_CDB_broadcast  in  1  CDB result valid
- in_CDB_tag  in  5  producer tag of result
- in_CDB_val  in  32  result value
- out_issue_valid  out  1  a ready entry is presented
- in_issue_ready  in  1  functional unit accepts
- out_issue_operator_type  out  5
- out_issue_val_1 / out_issue_val_2  out  32
- out_issue_tag  out  5  tag of issuing entry (destination tag for CDB)

## Operation
- Entry fields: busy, op, val_1, val_2, tag_1, tag_2. Entry ready = busy && tag_1 == INVALID_TAG && tag_2 == INVALID_TAG.
- Dispatch: out_dispatch_ready = some entry not busy (per Configuration). On valid && ready, write lowest-index free entry, set busy.
- Allocation report: on accept, register out_alloc_valid=1, out_alloc_tag=TAG_BASE+index; visible the following cycle for exactly one cycle.
- CDB capture: every busy entry with tag_k == in_CDB_tag while in_CDB_broadcast: val_k <= in_CDB_val, tag_k <= INVALID_TAG. Both operands may match the same broadcast. A CDB tag of INVALID_TAG never matches.
- Issue: out_issue_* driven combinationally from the lowest-index ready entry; out_issue_valid=0 when none. On valid && in_issue_ready, clear that entry's busy.
- Issue data is stable while valid && !ready unless a lower-index entry becomes ready; a lower-index entry then takes over the offer.

## Timing
- Reset (rst_n=0 at edge): all busy=0, tags=INVALID_TAG; out_alloc_valid=0, out_alloc_tag=INVALID_TAG; out_issue_valid=0, issue data/op 0, out_issue_tag=INVALID_TAG; out_dispatch_ready=1 (all entries free). Reset mid-operation discards all entries.
- Dispatch of fully ready operands at edge t: issuable from t+1.
- CDB capture at edge t: entry issuable from t+1 (no same-cycle wakeup-to-issue).
- Entry freed by issue at edge t: available for dispatch from t+1; the free vector is taken from registered state.
- Full (all busy): out_dispatch_ready=0 even if an issue completes that cycle.
- Dispatch and issue in the same cycle are independent; dispatch and CDB in the same cycle: see Configuration.

## Configuration
- RS_DISPATCH_BYPASS_EN defined: on dispatch, an incoming operand whose in_tag_k equals in_CDB_tag during in_CDB_broadcast is stored as in_CDB_val with INVALID_TAG; dispatch is never blocked by the CDB.
- Not defined: out_dispatch_ready forced 0 in any cycle with in_CDB_broadcast=1 (stall instead of forward); no bypass logic.

## Structure
- tomasulo_pkg: INVALID_TAG, TAG_W=5, DATA_W=32, OP_W=5, rs_entry_t struct (busy, op, val_1, val_2, tag_1, tag_2).
- Sub-module rs_prio_enc (DEPTH-wide lowest-set-bit select with found flag), instantiated twice: free-entry select and ready-entry select.

## Test plan
- Reset, dispatch op=3, val 10/20, tags INVALID -> alloc pulse tag 0 next cycle; issue valid with 10/20, tag 0; ready=1 frees entry.
- Dispatch tag_1=7, val_2=5; CDB tag 7 val 99 two cycles later -> issue 99/5 the cycle after the broadcast, not before.
- Fill DEPTH=4 with pending operands -> out_dispatch_ready=0; issue none; broadcast wakes entry 2 -> issues tag 2; dispatch ready again the cycle after.
- Two entries ready, hold in_issue_ready=0 three cycles -> entry 0 held stable; release -> entry 0 then entry 1 on consecutive cycles.
- Dispatch with in_tag_1=9 while CDB broadcasts tag 9 val 42 -> with macro: accepted, issues 42 next cycle; without: dispatch stalled one cycle, then accepted.
- Assert rst_n=0 with 3 busy entries -> next cycle all outputs at reset values, no alloc pulse, no issue.
